decode_output_queue: RTL and testbench

Final stage of the decode unit, replacing the fixed three-way A/B/D output mux. Takes `numFormats` format-specific decoder channels, picks the one enabled channel each cycle, and buffers decoded micro-ops in a `depth`-entry in-order queue with a valid/ready handshake toward dispatch. Upstream decode stages receive a stall that accounts for instructions already in flight. Decode no longer drops work when dispatch backs up.

---
 rtl/decode_pkg.sv | 81 ++++++++
 rtl/decode_fifo.sv | 86 ++++++++
 rtl/decode_output_queue.sv | 104 ++++++++++
 tb/tb_decode_output_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: micro-op payload layout, format one-hot codes
// and the channel-index to format mapping used by the output queue.
package decode_pkg;

    localparam int unsigned OPCODE_W   = 12;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned FUNCUNIT_W = 3;
    localparam int unsigned MAJID_W    = 64;
    localparam int unsigned MINID_W    = 7;
    localparam int unsigned IS64_W     = 1;
    localparam int unsigned PID_W      = 20;
    localparam int unsigned TID_W      = 16;
    localparam int unsigned OPRW_W     = 8;
    localparam int unsigned OPISREG_W  = 4;
    localparam int unsigned BODY_W     = 84;

    localparam int unsigned COLLISION_CNT_W = 16;

    // Fields are packed MSB-first in declaration order; body occupies the LSBs.
    localparam int unsigned BODY_LSB     = 0;
    localparam int unsigned OPISREG_LSB  = BODY_LSB + BODY_W;
    localparam int unsigned OPRW_LSB     = OPISREG_LSB + OPISREG_W;
    localparam int unsigned TID_LSB      = OPRW_LSB + OPRW_W;
    localparam int unsigned PID_LSB      = TID_LSB + TID_W;
    localparam int unsigned IS64_LSB     = PID_LSB + PID_W;
    localparam int unsigned MINID_LSB    = IS64_LSB + IS64_W;
    localparam int unsigned MAJID_LSB    = MINID_LSB + MINID_W;
    localparam int unsigned FUNCUNIT_LSB = MAJID_LSB + MAJID_W;
    localparam int unsigned ADDR_LSB     = FUNCUNIT_LSB + FUNCUNIT_W;
    localparam int unsigned OPCODE_LSB   = ADDR_LSB + ADDR_W;
    localparam int unsigned PAYLOAD_W    = OPCODE_LSB + OPCODE_W;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [ADDR_W-1:0]     address;
        logic [FUNCUNIT_W-1:0] funcUnit;
        logic [MAJID_W-1:0]    majId;
        logic [MINID_W-1:0]    minId;
        logic                  is64Bit;
        logic [PID_W-1:0]      pid;
        logic [TID_W-1:0]      tid;
        logic [OPRW_W-1:0]     opRw;
        logic [OPISREG_W-1:0]  opIsReg;
        logic [BODY_W-1:0]     body;
    } decodedOp_t;

    typedef enum logic [7:0] {
        FMT_NONE = 8'h00,
        FMT_I    = 8'h01,
        FMT_B    = 8'h02,
        FMT_XL   = 8'h04,
        FMT_D    = 8'h08,
        FMT_DS   = 8'h10,
        FMT_X    = 8'h20,
        FMT_XX2  = 8'h40,
        FMT_XX3  = 8'h80
    } fmt_e;

    function automatic logic [PAYLOAD_W-1:0] packOp(input decodedOp_t op);
        return op;
    endfunction

    function automatic fmt_e fmtFromSel(input logic [4:0] sel);
        case (sel)
            5'd0:    return FMT_I;
            5'd1:    return FMT_B;
            5'd2:    return FMT_XL;
            5'd3:    return FMT_D;
            5'd4:    return FMT_DS;
            5'd5:    return FMT_X;
            5'd6:    return FMT_XX2;
            5'd7:    return FMT_XX3;
            default: return FMT_NONE;
        endcase
    endfunction

    function automatic int unsigned selWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// In-order depth x width FIFO with show-ahead registered head, flush, and
// separately tracked occupancy so full and empty stay distinct.
module decode_fifo #(
    parameter int unsigned depth = 4,
    parameter int unsigned width = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [width-1:0]           data_i,
    output logic [width-1:0]           data_o,
    output logic [$clog2(depth):0]     count_o,
    output logic [$clog2(depth):0]     countNext_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic [width-1:0] head;
    logic             pushEff;
    logic             popEff;
    logic             writeEn;

    assign full_o      = (count == CNT_W'(depth));
    assign empty_o     = (count == '0);
    assign count_o     = count;
    assign countNext_o = countNext;
    assign data_o      = head;

    // A push into a full queue is only taken when the head leaves the same cycle.
    assign popEff  = pop_i && !empty_o;
    assign pushEff = push_i && (!full_o || popEff);
    assign writeEn = pushEff && !flush_i && !reset_i;
    assign rdNext  = popEff ? rdPtr + 1'b1 : rdPtr;

    always_comb begin
        countNext = count;
        if (flush_i) begin
            countNext = '0;
        end else if (pushEff && !popEff) begin
            countNext = count + 1'b1;
        end else if (popEff && !pushEff) begin
            countNext = count - 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (writeEn) begin
            mem[wrPtr] <= data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            head  <= '0;
        end else if (flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEff) begin
                wrPtr <= wrPtr + 1'b1;
            end
            rdPtr <= rdNext;
            count <= countNext;
            // Head is refilled from the incoming word when it lands in the new head slot.
            if (countNext != '0) begin
                head <= (pushEff && (wrPtr == rdNext)) ? data_i : mem[rdNext];
            end
        end
    end

endmodule

// File: rtl/decode_output_queue.sv
// Decode output stage: arbitrates format-decoder channels into an in-order
// queue toward dispatch, with upstream stall, collision and overflow status.
module decode_output_queue
    import decode_pkg::*;
#(
    parameter int unsigned numFormats        = 3,
    parameter int unsigned payloadWidth      = PAYLOAD_W,
    parameter int unsigned depth             = 4,
    parameter int unsigned stallThreshold    = 2,
    parameter int unsigned collisionCntWidth = COLLISION_CNT_W
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic [numFormats-1:0]              fmtEnable_i,
    input  logic [numFormats*payloadWidth-1:0] fmtPayload_i,
    input  logic                               ready_i,
    output logic                               valid_o,
    output logic [payloadWidth-1:0]            payload_o,
    output logic [selWidth(numFormats)-1:0]    fmtSel_o,
    output logic                               stall_o,
    output logic                               collision_o,
    output logic [collisionCntWidth-1:0]       collisionCnt_o,
    output logic                               overflow_o,
    output logic [$clog2(depth):0]             count_o
);

    localparam int unsigned SEL_W   = selWidth(numFormats);
    localparam int unsigned ENTRY_W = payloadWidth + SEL_W;
    localparam int unsigned CNT_W   = $clog2(depth) + 1;

    logic [SEL_W-1:0]        winSel;
    logic [payloadWidth-1:0] winPayload;
    logic                    found;
    logic                    collide;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [CNT_W-1:0]        countNext;
    logic [ENTRY_W-1:0]      headEntry;

    // Lowest enabled index wins; any further enabled channel marks a collision.
    always_comb begin
        winSel     = '0;
        winPayload = '0;
        found      = 1'b0;
        collide    = 1'b0;
        for (int unsigned k = 0; k < numFormats; k++) begin
            if (fmtEnable_i[k]) begin
                if (found) begin
                    collide = 1'b1;
                end else begin
                    found      = 1'b1;
                    winSel     = SEL_W'(k);
                    winPayload = fmtPayload_i[k*payloadWidth +: payloadWidth];
                end
            end
        end
    end

    assign push    = found;
    assign pop     = valid_o && ready_i;
    assign valid_o = !empty;

    decode_fifo #(
        .depth (depth),
        .width (ENTRY_W)
    ) fifo (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .pop_i       (pop),
        .data_i      ({winSel, winPayload}),
        .data_o      (headEntry),
        .count_o     (count_o),
        .countNext_o (countNext),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign fmtSel_o  = headEntry[ENTRY_W-1 -: SEL_W];
    assign payload_o = headEntry[payloadWidth-1:0];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_o        <= 1'b0;
            collision_o    <= 1'b0;
            collisionCnt_o <= '0;
            overflow_o     <= 1'b0;
        end else begin
            stall_o     <= (32'(depth) - 32'(countNext)) <= 32'(stallThreshold);
            collision_o <= collide && !flush_i;
            if (collide && !flush_i && (collisionCnt_o != '1)) begin
                collisionCnt_o <= collisionCnt_o + 1'b1;
            end
            if (push && full && !pop && !flush_i) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_output_queue.sv
// Directed bench for decode_output_queue: handshake, arbitration, backpressure,
// wrap-around, flush and mid-stream reset.
module tb_decode_output_queue;

    localparam int unsigned NF  = 3;
    localparam int unsigned PW  = 283;
    localparam int unsigned DEP = 4;
    localparam int unsigned CW  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [NF-1:0]     en = '0;
    logic [NF*PW-1:0]  pay = '0;
    logic              ready = 1'b0;
    logic              valid;
    logic [PW-1:0]     payload;
    logic [1:0]        fmtSel;
    logic              stall;
    logic              collision;
    logic [CW-1:0]     collisionCnt;
    logic              overflow;
    logic [2:0]        count;

    int unsigned nChecks = 0;
    int unsigned nErrors = 0;

    decode_output_queue #(
        .numFormats        (NF),
        .payloadWidth      (PW),
        .depth             (DEP),
        .stallThreshold    (2),
        .collisionCntWidth (CW)
    ) dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .flush_i        (flush),
        .fmtEnable_i    (en),
        .fmtPayload_i   (pay),
        .ready_i        (ready),
        .valid_o        (valid),
        .payload_o      (payload),
        .fmtSel_o       (fmtSel),
        .stall_o        (stall),
        .collision_o    (collision),
        .collisionCnt_o (collisionCnt),
        .overflow_o     (overflow),
        .count_o        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] P(input logic [7:0] b);
        logic [287:0] t;
        t = {36{b}};
        return t[PW-1:0];
    endfunction

    task automatic setCh(input int unsigned k, input logic [PW-1:0] v);
        pay[k*PW +: PW] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", 288'(valid), 288'(0));
        check("rst_count", 288'(count), 288'(0));
        check("rst_stall", 288'(stall), 288'(0));
        check("rst_coll", 288'(collision), 288'(0));
        check("rst_cnt", 288'(collisionCnt), 288'(0));
        check("rst_ovf", 288'(overflow), 288'(0));
        check("rst_payload", 288'(payload), 288'(0));
        check("rst_sel", 288'(fmtSel), 288'(0));

        // Single push on channel 1, dispatch ready
        en = 3'b010; setCh(1, P(8'hA5)); ready = 1'b1;
        tick();
        en = '0;
        check("single_valid", 288'(valid), 288'(1));
        check("single_sel", 288'(fmtSel), 288'(1));
        check("single_payload", 288'(payload), 288'(P(8'hA5)));
        check("single_count", 288'(count), 288'(1));
        tick();
        check("single_drained", 288'(valid), 288'(0));
        check("single_hold", 288'(payload), 288'(P(8'hA5)));

        // Collision: channels 1 and 2, channel 1 wins
        ready = 1'b0; en = 3'b110; setCh(1, P(8'h11)); setCh(2, P(8'h22));
        tick();
        en = '0;
        check("coll_pulse", 288'(collision), 288'(1));
        check("coll_cnt1", 288'(collisionCnt), 288'(1));
        check("coll_sel", 288'(fmtSel), 288'(1));
        check("coll_payload", 288'(payload), 288'(P(8'h11)));
        check("coll_count", 288'(count), 288'(1));
        tick();
        check("coll_pulse_end", 288'(collision), 288'(0));
        ready = 1'b1;
        tick();
        check("coll_drain", 288'(count), 288'(0));

        // Saturation of the 2-bit counter
        en = 3'b011; setCh(0, P(8'h31)); setCh(1, P(8'h32));
        tick();
        check("sat_sel", 288'(fmtSel), 288'(0));
        check("sat_payload", 288'(payload), 288'(P(8'h31)));
        check("sat_cnt2", 288'(collisionCnt), 288'(2));
        tick();
        check("sat_cnt3", 288'(collisionCnt), 288'(3));
        tick();
        check("sat_hold", 288'(collisionCnt), 288'(3));
        check("sat_pulse", 288'(collision), 288'(1));
        check("sat_count", 288'(count), 288'(1));
        en = '0;
        tick();
        check("sat_empty", 288'(count), 288'(0));

        // Backpressure: four pushes fill, fifth overflows
        ready = 1'b0; en = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            setCh(0, P(8'(i)));
            tick();
            if (i == 1) check("bp_stall1", 288'(stall), 288'(0));
            if (i == 2) check("bp_stall2", 288'(stall), 288'(1));
            if (i == 4) check("bp_ovf_before", 288'(overflow), 288'(0));
        end
        en = '0;
        check("bp_count", 288'(count), 288'(4));
        check("bp_ovf", 288'(overflow), 288'(1));
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("bp_drain%0d", i), 288'(payload), 288'(P(8'(i))));
            tick();
        end
        check("bp_empty", 288'(valid), 288'(0));
        check("bp_unstall", 288'(stall), 288'(0));

        // Full queue with simultaneous push and pop
        ready = 1'b0; en = 3'b001;
        for (int i = 0; i < 4; i++) begin
            setCh(0, P(8'(8'h10 + i)));
            tick();
        end
        setCh(0, P(8'h14)); ready = 1'b1;
        tick();
        en = '0;
        check("fpp_count", 288'(count), 288'(4));
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fpp_out%0d", i), 288'(payload), 288'(P(8'(8'h10 + i))));
            tick();
        end
        check("fpp_empty", 288'(count), 288'(0));

        // Sustained streaming across pointer wrap
        en = 3'b001;
        for (int i = 0; i < 12; i++) begin
            setCh(0, P(8'(8'h40 + i)));
            tick();
            check($sformatf("wrap%0d", i), 288'(payload), 288'(P(8'(8'h40 + i))));
        end
        check("wrap_count", 288'(count), 288'(1));
        en = '0;
        tick();
        check("wrap_empty", 288'(count), 288'(0));

        // Flush with a same-cycle push
        ready = 1'b0; en = 3'b001;
        for (int i = 0; i < 3; i++) begin
            setCh(0, P(8'(8'h60 + i)));
            tick();
        end
        check("fl_count3", 288'(count), 288'(3));
        check("fl_stall3", 288'(stall), 288'(1));
        flush = 1'b1; setCh(0, P(8'h63));
        tick();
        flush = 1'b0;
        check("fl_valid", 288'(valid), 288'(0));
        check("fl_count", 288'(count), 288'(0));
        check("fl_ovf_kept", 288'(overflow), 288'(1));
        check("fl_stall", 288'(stall), 288'(0));
        setCh(0, P(8'h70));
        tick();
        check("fl_after_valid", 288'(valid), 288'(1));
        check("fl_after_payload", 288'(payload), 288'(P(8'h70)));

        // Reset mid-stream
        setCh(0, P(8'h71));
        tick();
        en = '0;
        check("mr_count2", 288'(count), 288'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_valid", 288'(valid), 288'(0));
        check("mr_count", 288'(count), 288'(0));
        check("mr_stall", 288'(stall), 288'(0));
        check("mr_coll", 288'(collision), 288'(0));
        check("mr_cnt", 288'(collisionCnt), 288'(0));
        check("mr_ovf", 288'(overflow), 288'(0));
        check("mr_payload", 288'(payload), 288'(0));
        check("mr_sel", 288'(fmtSel), 288'(0));

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
